// File: rtl/collision_scanner.sv
// ============================================================================
// Module   : collision_scanner
// Purpose  : Walks the 4x4 block window one cell per clock, drives the per-cell
//            checker and folds its verdicts into a single collision result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_scanner #(
    parameter int FIELD_W    = 20,
    parameter int FIELD_H    = 20,
    parameter int EARLY_EXIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] pos_x,
    input  logic [4:0] pos_y,
    input  logic       check_result,
    output logic [4:0] b_x,
    output logic [4:0] b_y,
    output logic [4:0] block_pos_x,
    output logic [4:0] block_pos_y,
    output logic [3:0] block_index,
    output logic [8:0] field_index,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       collision
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_FIELD_W6 = 6'(FIELD_W);
    localparam logic [5:0] c_FIELD_H6 = 6'(FIELD_H);
    localparam logic [8:0] c_FIELD_W9 = 9'(FIELD_W);

    state_t     state_q, state_d;
    logic [3:0] k_q, k_d;
    logic [4:0] bpx_q, bpx_d;
    logic [4:0] bpy_q, bpy_d;
    logic       acc_q, acc_d;
    logic       coll_q, coll_d;

    logic [5:0] w_sum_x;
    logic [5:0] w_sum_y;
    logic       w_oob;
    logic [8:0] w_flat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
            bpx_q   <= 5'd0;
            bpy_q   <= 5'd0;
            acc_q   <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            bpx_q   <= bpx_d;
            bpy_q   <= bpy_d;
            acc_q   <= acc_d;
            coll_q  <= coll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        bpx_d   = bpx_q;
        bpy_d   = bpy_q;
        acc_d   = acc_q;
        coll_d  = coll_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bpx_d   = pos_x;
                    bpy_d   = pos_y;
                    k_d     = 4'd0;
                    acc_d   = 1'b0;
                    coll_d  = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // The counter is left on the exit cell so the outputs keep
                // showing the last presented cell through DONE and IDLE.
                if (check_result && (EARLY_EXIT != 0)) begin
                    coll_d  = 1'b1;
                    state_d = S_DONE;
                end else if (k_q == 4'd15) begin
                    coll_d  = acc_q | check_result;
                    state_d = S_DONE;
                end else begin
                    acc_d = acc_q | check_result;
                    k_d   = k_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // 6-bit sums cannot wrap for any 5-bit position plus a 2-bit offset.
    assign w_sum_x = {1'b0, bpx_q} + {4'b0000, k_q[1:0]};
    assign w_sum_y = {1'b0, bpy_q} + {4'b0000, k_q[3:2]};
    assign w_oob   = (w_sum_x >= c_FIELD_W6) || (w_sum_y >= c_FIELD_H6);
    assign w_flat  = ({3'b000, w_sum_y} * c_FIELD_W9) + {3'b000, w_sum_x};

    assign b_x         = {3'b000, k_q[1:0]};
    assign b_y         = {3'b000, k_q[3:2]};
    assign block_index = k_q;
    assign field_index = w_oob ? 9'd0 : w_flat;
    assign block_pos_x = bpx_q;
    assign block_pos_y = bpy_q;
    assign ready       = (state_q == S_IDLE);
    assign busy        = (state_q == S_SCAN);
    assign done        = (state_q == S_DONE);
    assign collision   = coll_q;

endmodule

`default_nettype wire

// File: tb/tb_collision_scanner.sv
// ============================================================================
// Module   : tb_collision_scanner
// Purpose  : Drives an early-exit and a full-scan scanner side by side against
//            a cell-list reference of the collision rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collision_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] pos_x = 5'd0;
    logic [4:0] pos_y = 5'd0;

    logic [1:0]      cr;
    logic [1:0][4:0] bx, by, bpx, bpy;
    logic [1:0][3:0] bi;
    logic [1:0][8:0] fi;
    logic [1:0]      rdy, bsy, dn, col;

    logic [15:0]  blk = 16'h0;
    logic [399:0] fld = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    collision_scanner #(.FIELD_W(20), .FIELD_H(20), .EARLY_EXIT(1)) u_dut_ee (
        .clk(clk), .rst(rst), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .check_result(cr[0]), .b_x(bx[0]), .b_y(by[0]),
        .block_pos_x(bpx[0]), .block_pos_y(bpy[0]), .block_index(bi[0]),
        .field_index(fi[0]), .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
        .collision(col[0])
    );

    collision_scanner #(.FIELD_W(20), .FIELD_H(20), .EARLY_EXIT(0)) u_dut_full (
        .clk(clk), .rst(rst), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .check_result(cr[1]), .b_x(bx[1]), .b_y(by[1]),
        .block_pos_x(bpx[1]), .block_pos_y(bpy[1]), .block_index(bi[1]),
        .field_index(fi[1]), .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
        .collision(col[1])
    );

    // Environment checker: occupied block cell that lands off-field or on an
    // occupied field cell.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cr[i] = blk[bi[i]] &&
                    ((int'(bpx[i]) + int'(bx[i]) >= 20) ||
                     (int'(bpy[i]) + int'(by[i]) >= 20) ||
                     fld[(int'(bpy[i]) + int'(by[i])) * 20 + int'(bpx[i]) + int'(bx[i])]);
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int first_hit(input int px, input int py);
        for (int k = 0; k < 16; k++) begin
            int sx, sy;
            sx = px + k % 4;
            sy = py + k / 4;
            if (blk[k] && (sx >= 20 || sy >= 20 || fld[sy * 20 + sx])) return k;
        end
        return 16;
    endfunction

    function automatic int exp_fi(input int px, input int py, input int k);
        int sx, sy;
        sx = px + k % 4;
        sy = py + k / 4;
        return (sx < 20 && sy < 20) ? sy * 20 + sx : 0;
    endfunction

    // Cycle n is the n-th clock period after the accepting edge.
    task automatic run_query(input int px, input int py, input int pulse_n);
        int fh, vd, dc, k;
        int endk[2];
        fh = first_hit(px, py);
        vd = (fh < 16) ? 1 : 0;
        endk[0] = (fh < 16) ? fh : 15;
        endk[1] = 15;
        @(negedge clk);
        pos_x = 5'(px);
        pos_y = 5'(py);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            for (int i = 0; i < 2; i++) begin
                dc = endk[i] + 2;
                if (n < dc) begin
                    chk($sformatf("busy[%0d] n=%0d", i, n), int'(bsy[i]), 1);
                    chk($sformatf("ready[%0d] n=%0d", i, n), int'(rdy[i]), 0);
                    chk($sformatf("done[%0d] n=%0d", i, n), int'(dn[i]), 0);
                    k = n - 1;
                end else if (n == dc) begin
                    chk($sformatf("done[%0d] n=%0d", i, n), int'(dn[i]), 1);
                    chk($sformatf("busy[%0d] n=%0d", i, n), int'(bsy[i]), 0);
                    chk($sformatf("ready[%0d] n=%0d", i, n), int'(rdy[i]), 0);
                    chk($sformatf("collision[%0d] n=%0d", i, n), int'(col[i]), vd);
                    k = endk[i];
                end else begin
                    chk($sformatf("ready[%0d] n=%0d", i, n), int'(rdy[i]), 1);
                    chk($sformatf("done[%0d] n=%0d", i, n), int'(dn[i]), 0);
                    chk($sformatf("held_coll[%0d] n=%0d", i, n), int'(col[i]), vd);
                    k = endk[i];
                end
                if (n <= dc) begin
                    chk($sformatf("b_x[%0d] n=%0d", i, n), int'(bx[i]), k % 4);
                    chk($sformatf("b_y[%0d] n=%0d", i, n), int'(by[i]), k / 4);
                    chk($sformatf("bidx[%0d] n=%0d", i, n), int'(bi[i]), k);
                    chk($sformatf("fidx[%0d] n=%0d", i, n), int'(fi[i]), exp_fi(px, py, k));
                    chk($sformatf("bpos_x[%0d] n=%0d", i, n), int'(bpx[i]), px);
                    chk($sformatf("bpos_y[%0d] n=%0d", i, n), int'(bpy[i]), py);
                end
            end
            start = (n == pulse_n) ? 1'b1 : 1'b0;
            pos_x = 5'($urandom_range(0, 19));
            pos_y = 5'($urandom_range(0, 19));
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int dcount;
        #12;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ready[%0d]", i), int'(rdy[i]), 1);
            chk($sformatf("rst_busy[%0d]", i), int'(bsy[i]), 0);
            chk($sformatf("rst_done[%0d]", i), int'(dn[i]), 0);
            chk($sformatf("rst_coll[%0d]", i), int'(col[i]), 0);
            chk($sformatf("rst_bxy[%0d]", i), int'({bx[i], by[i]}), 0);
            chk($sformatf("rst_bpos[%0d]", i), int'({bpx[i], bpy[i]}), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // T-piece on an empty field, with start re-pulsed mid-scan.
        blk = 16'h0072;
        fld = '0;
        run_query(5, 5, 5);
        // Same, with start pulsed in the DONE cycle.
        run_query(5, 5, 17);

        // Single colliding cell at k=5, field index 126.
        blk = 16'h0020;
        fld = '0;
        fld[126] = 1'b1;
        run_query(5, 5, 0);

        // Right column hangs off the field at x=21.
        blk = 16'h8888;
        fld = '0;
        run_query(18, 0, 0);

        // Asynchronous reset in the middle of a scan.
        blk = 16'hFFFF;
        fld = '0;
        @(negedge clk);
        pos_x = 5'd2;
        pos_y = 5'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_bidx", int'(bi[0]), 8);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("arst_ready[%0d]", i), int'(rdy[i]), 1);
            chk($sformatf("arst_busy[%0d]", i), int'(bsy[i]), 0);
            chk($sformatf("arst_done[%0d]", i), int'(dn[i]), 0);
            chk($sformatf("arst_bxy[%0d]", i), int'({bx[i], by[i]}), 0);
            chk($sformatf("arst_bpos[%0d]", i), int'({bpx[i], bpy[i]}), 0);
            chk($sformatf("arst_coll[%0d]", i), int'(col[i]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            if (dn != 2'b00) dcount++;
            @(negedge clk);
        end
        chk("no_done_after_rst", dcount, 0);
        run_query(2, 2, 0);

        // Random positions, blocks and fields.
        for (int t = 0; t < 12; t++) begin
            blk = 16'($urandom) & 16'($urandom);
            for (int j = 0; j < 400; j++) fld[j] = ($urandom_range(0, 9) == 0);
            run_query(int'($urandom_range(0, 19)), int'($urandom_range(0, 19)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
Sequential driver for the per-cell block/field collision checker. On a start request it latches the candidate piece position and walks the 16 cells of the 4x4 block window, one cell per clock. For each cell it presents the cell offsets and the flat block/field indices to the checker, then accumulates the checker's 1-bit result into a single collision verdict. It sits between the game-control FSM (move/rotate/drop legality queries) and the combinational checker.

Parameters:
FIELD_W, 20, playfield width in cells; field_index row stride.
FIELD_H, 20, playfield height in cells.
EARLY_EXIT, 1, 1 = finish on the first colliding cell; 0 = always scan all 16 cells.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  query request; accepted only while ready=1
pos_x  input  5  candidate piece column; legal range 0..19; sampled on accept
pos_y  input  5  candidate piece row; legal range 0..19; sampled on accept
check_result  input  1  checker verdict for the currently presented cell (combinational, same cycle)
b_x  output  5  cell column offset within the 4x4 window (0..3)
b_y  output  5  cell row offset within the 4x4 window (0..3)
block_pos_x  output  5  latched pos_x
block_pos_y  output  5  latched pos_y
block_index  output  4  b_y*4 + b_x
field_index  output  9  (block_pos_y+b_y)*FIELD_W + (block_pos_x+b_x) when in bounds, else 0
ready  output  1  high in IDLE
busy  output  1  high in SCAN
done  output  1  one-cycle pulse; collision is valid in this cycle
collision  output  1  query verdict; held until the next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; b_x=b_y=0; block_pos_x=block_pos_y=0; collision=0; done=0; busy=0; ready=1. Reset during SCAN aborts the query with no done pulse.
- States:
  - IDLE: on start=1, latch pos_x/pos_y, clear collision and cell counter, go to SCAN. Otherwise stay.
  - SCAN: present cell k (b_x=k[1:0], b_y=k[3:2], k=0..15, row-major). Sample check_result at the end of the cycle. If check_result=1 and EARLY_EXIT=1, set collision=1 and go to DONE. If k=15, set collision to the OR of all sampled results and go to DONE. Otherwise k+1.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - Start accepted at edge E0; cell 0 is presented in the cycle after E0.
  - No collision: 16 SCAN cycles, then done in the 17th cycle after E0.
  - Early exit at cell k: done in cycle k+2 after E0.
- start while busy or in DONE is ignored and not queued. start in the same cycle as done is ignored; ready is low in DONE.
- Index arithmetic: compute sums at 6 bits (max 19+3=22), so they never wrap. A cell is out of bounds if sum_x>=FIELD_W or sum_y>=FIELD_H; field_index is then forced to 0. The row product is at most 22*20+22, which fits in 9 bits before the bound check.
- b_x, b_y, block_index and field_index are registered-state derived and glitch-free at the cycle boundary. In IDLE/DONE they hold the last presented values.
- Out-of-range pos (>19) is illegal input; behaviour is unspecified but the block must not hang.

Test Plan:
- Empty field, T-piece, pos (5,5), start pulse -> busy for 16 cycles, b_x/b_y sweep (0,0)..(3,3), done at cycle 17 after accept, collision=0.
- Field cell at index 6*20+6=126 occupied, block bit 5 set, pos (5,5), EARLY_EXIT=1 -> collision=1, done at cycle 7 (k=5), last field_index=126.
- Same stimulus with EARLY_EXIT=0 -> done at cycle 17, collision=1.
- pos (18,0), block column 3 occupied -> cell (3,0) reports sum_x=21, field_index=0; checker flags out of bounds; collision=1.
- start re-pulsed during SCAN at k=4 -> ignored; single done, verdict of the original query.
- rst asserted asynchronously mid-SCAN at k=8 -> outputs immediately at reset values, no done; a new start afterwards completes normally.
